// File: rtl/tff_pkg.sv
// Purpose    : shared constants and types for the toggle flip-flop bank.
// Latency    : n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   TFF_MAX_WIDTH     - largest legal bank width.
//   TFF_CNT_W_DEFAULT - default width of the optional toggle event counter.
//   tff_cnt_t         - counter vector type at the default width.
package tff_pkg;

    localparam int unsigned TFF_MAX_WIDTH     = 64;
    localparam int unsigned TFF_CNT_W_DEFAULT = 16;

    typedef logic [TFF_CNT_W_DEFAULT-1:0] tff_cnt_t;

endpackage : tff_pkg

// File: rtl/tff_bit.sv
// Purpose    : single toggle register; inverts on t=1, holds on t=0.
// Latency    : q changes one rising edge after t is sampled; no t->q comb path.
// Backpressure: none; t is sampled on every edge.
//
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset, wins over t
//   t       - toggle enable
//   rst_val - value loaded into q on reset
//   q       - registered state
module tff_bit (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic rst_val,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= rst_val;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule : tff_bit

// File: rtl/toggle_ff.sv
// Purpose    : bank of WIDTH independent T flip-flops with true and complement outputs.
// Latency    : Q/notQ update one rising edge after T is sampled; notQ is ~Q combinationally.
// Backpressure: none; T is sampled on every edge, reset has priority.
//
// Ports:
//   clk        - rising-edge clock, the only clock
//   rst        - synchronous active-high reset (Q <= RESET_VAL, counter <= 0)
//   T          - per-bit toggle enable
//   Q          - registered state
//   notQ       - bitwise complement of Q
//   toggle_cnt - (only with TFF_TOGGLE_COUNT_EN) number of edges on which any
//                bit toggled, modulo 2^CNT_W
//
// Build option: define TFF_TOGGLE_COUNT_EN to add the toggle_cnt port and counter.
module toggle_ff
    import tff_pkg::*;
#(
    parameter int unsigned        WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
    parameter int unsigned        CNT_W     = $bits(tff_cnt_t)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  T,
    output logic [WIDTH-1:0]  Q,
`ifdef TFF_TOGGLE_COUNT_EN
    output logic [WIDTH-1:0]  notQ,
    output logic [CNT_W-1:0]  toggle_cnt
`else
    output logic [WIDTH-1:0]  notQ
`endif
);

    // Reject illegal configurations at elaboration time.
    generate
        if (WIDTH < 1 || WIDTH > TFF_MAX_WIDTH) begin : g_bad_width
            $error("toggle_ff: WIDTH must be in 1..%0d", TFF_MAX_WIDTH);
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("toggle_ff: CNT_W must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] w_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            tff_bit u_bit (
                .clk     (clk),
                .rst     (rst),
                .t       (T[gi]),
                .rst_val (RESET_VAL[gi]),
                .q       (w_q[gi])
            );
        end
    endgenerate

    // notQ is taken from the same registered vector so the two outputs can
    // never be observed equal, including across reset.
    assign Q    = w_q;
    assign notQ = ~w_q;

`ifdef TFF_TOGGLE_COUNT_EN
    logic [CNT_W-1:0] r_toggle_cnt;

    // Counts edges, not bits: several bits toggling together count once.
    // Free-running wrap, no saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_toggle_cnt <= '0;
        end else if (|T) begin
            r_toggle_cnt <= r_toggle_cnt + CNT_W'(1);
        end
    end

    assign toggle_cnt = r_toggle_cnt;
`endif

endmodule : toggle_ff

// File: tb/tb_toggle_ff.sv
module tb_toggle_ff;

    localparam int WA = 4;
    localparam logic [WA-1:0] RV_A = 4'b0000;
    localparam logic          RV_B = 1'b1;
    localparam int CNT_A = 16;
    localparam int CNT_B = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [WA-1:0] t_a = '1;
    logic          t_b = 1'b1;
    logic [WA-1:0] q_a, nq_a;
    logic          q_b, nq_b;
`ifdef TFF_TOGGLE_COUNT_EN
    logic [CNT_A-1:0] cnt_a;
    logic [CNT_B-1:0] cnt_b;
`endif

    always #5 clk = ~clk;

    toggle_ff #(.WIDTH(WA), .RESET_VAL(RV_A), .CNT_W(CNT_A)) u_dut_a (
        .clk  (clk),
        .rst  (rst),
        .T    (t_a),
        .Q    (q_a),
`ifdef TFF_TOGGLE_COUNT_EN
        .notQ (nq_a),
        .toggle_cnt (cnt_a)
`else
        .notQ (nq_a)
`endif
    );

    toggle_ff #(.WIDTH(1), .RESET_VAL(RV_B), .CNT_W(CNT_B)) u_dut_b (
        .clk  (clk),
        .rst  (rst),
        .T    (t_b),
        .Q    (q_b),
`ifdef TFF_TOGGLE_COUNT_EN
        .notQ (nq_b),
        .toggle_cnt (cnt_b)
`else
        .notQ (nq_b)
`endif
    );

    // Expected state after one edge, pushed by stimulus, popped by the monitor.
    typedef struct {
        logic [WA-1:0] qa;
        logic          qb;
        int            ca;
        int            cb;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model: each bit's value is its reset value XOR the parity of
    // the number of toggle requests it has received since the last reset.
    int tog_a[WA];
    int tog_b;
    int ev_a;
    int ev_b;

    task automatic step(input logic r, input logic [WA-1:0] ta, input logic tb);
        exp_t e;
        @(negedge clk);
        rst = r;
        t_a = ta;
        t_b = tb;
        if (r) begin
            for (int i = 0; i < WA; i++) tog_a[i] = 0;
            tog_b = 0;
            ev_a  = 0;
            ev_b  = 0;
        end else begin
            for (int i = 0; i < WA; i++) if (ta[i]) tog_a[i] += 1;
            if (tb) tog_b += 1;
            if (ta != '0) ev_a += 1;
            if (tb) ev_b += 1;
        end
        for (int i = 0; i < WA; i++) e.qa[i] = RV_A[i] ^ ((tog_a[i] % 2) == 1);
        e.qb = RV_B ^ ((tog_b % 2) == 1);
        e.ca = ev_a % (1 << CNT_A);
        e.cb = ev_b % (1 << CNT_B);
        sb.push_back(e);
    endtask

    task automatic check_vec(input string name, input logic [WA-1:0] act, input logic [WA-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_vec("q_a", q_a, e.qa);
                check_vec("notq_a", nq_a, ~e.qa);
                check_vec("q_b", {3'b000, q_b}, {3'b000, e.qb});
                check_vec("notq_b", {3'b000, nq_b}, {3'b000, ~e.qb});
`ifdef TFF_TOGGLE_COUNT_EN
                check_int("cnt_a", int'(cnt_a), e.ca);
                check_int("cnt_b", int'(cnt_b), e.cb);
`endif
            end
        end
    end

    // notQ must be the complement of Q at every sample, not just on checked edges.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0 || checks > 0) begin
                check_vec("compl_a", nq_a, ~q_a);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WA-1:0] rt;
        // Reset with toggles requested: reset must win.
        step(1'b1, 4'b1111, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        // Hold.
        repeat (3) step(1'b0, 4'b0000, 1'b0);
        // Two toggles then hold.
        repeat (2) step(1'b0, 4'b1111, 1'b1);
        repeat (3) step(1'b0, 4'b0000, 1'b0);
        // Continuous toggle: divide by two.
        repeat (8) step(1'b0, 4'b1111, 1'b1);
        // Drive Q to 1, then reset while toggling, then resume.
        step(1'b0, 4'b1111, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        step(1'b0, 4'b1111, 1'b1);
        // Per-bit independence and counter wrap on the narrow counter.
        step(1'b1, 4'b0000, 1'b0);
        repeat (3) step(1'b0, 4'b1010, 1'b1);
        repeat (2) step(1'b0, 4'b0000, 1'b1);
        // Randomized traffic with occasional resets.
        for (int n = 0; n < 200; n++) begin
            rt = WA'($urandom);
            step(($urandom_range(0, 19) == 0), rt, 1'($urandom));
        end
        step(1'b0, 4'b0000, 1'b0);
        // Every pushed expectation must have been consumed.
        repeat (3) @(posedge clk);
        #2;
        check_int("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_toggle_ff
